// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths and the operand-fetch state encoding.
package cpu_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int ADDR_SIZE_DEF = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2
    } of_state_t;

endpackage

// File: rtl/of_bypass.sv
// Per-source operand select: x0/unused -> 0, then live writeback,
// then writeback captured at accept, then register-file data.
module of_bypass #(
    parameter int XLEN      = 32,
    parameter int ADDR_SIZE = 6
) (
    input  logic                 use_i,
    input  logic [ADDR_SIZE-1:0] rs_i,
    input  logic                 wb_valid_i,
    input  logic [ADDR_SIZE-1:0] wb_rd_i,
    input  logic [XLEN-1:0]      wb_data_i,
    input  logic                 cap_valid_i,
    input  logic [ADDR_SIZE-1:0] cap_rd_i,
    input  logic [XLEN-1:0]      cap_data_i,
    input  logic [XLEN-1:0]      rf_data_i,
    output logic [XLEN-1:0]      op_o,
    output logic                 wb_hit_o
);

    logic src_live;
    logic cap_hit;

    // A nonzero rs makes the address compares implicitly reject writes to x0.
    assign src_live = use_i && (rs_i != '0);
    assign wb_hit_o = src_live && wb_valid_i && (wb_rd_i == rs_i);
    assign cap_hit  = src_live && cap_valid_i && (cap_rd_i == rs_i);

    // Priority mux, newest data wins.
    always_comb begin
        op_o = '0;
        if (!src_live)     op_o = '0;
        else if (wb_hit_o) op_o = wb_data_i;
        else if (cap_hit)  op_o = cap_data_i;
        else               op_o = rf_data_i;
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts a decoded instruction, reads the register
// file with one-cycle latency, bypasses writeback data, and presents the
// operands downstream with a valid/ready handshake.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    // decode side
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [ADDR_SIZE-1:0] dec_rs1,
    input  logic [ADDR_SIZE-1:0] dec_rs2,
    input  logic                 dec_use_rs1,
    input  logic                 dec_use_rs2,
    input  logic [ADDR_SIZE-1:0] dec_rd,
    // register-file read
    output logic                 rf_read_enable1,
    output logic                 rf_read_enable2,
    output logic [ADDR_SIZE-1:0] rf_read_addr1,
    output logic [ADDR_SIZE-1:0] rf_read_addr2,
    input  logic [XLEN-1:0]      rf_read_data1,
    input  logic [XLEN-1:0]      rf_read_data2,
    // register-file write
    output logic                 rf_write_enable,
    output logic [ADDR_SIZE-1:0] rf_write_addr,
    output logic [XLEN-1:0]      rf_write_data,
    // writeback
    input  logic                 wb_valid,
    input  logic [ADDR_SIZE-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    // execute side
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [XLEN-1:0]      ex_op1,
    output logic [XLEN-1:0]      ex_op2,
    output logic [ADDR_SIZE-1:0] ex_rd
);

    of_state_t            state_q;
    logic [ADDR_SIZE-1:0] rs1_q, rs2_q, rd_q;
    logic                 use1_q, use2_q;
    logic                 cap_valid_q;
    logic [ADDR_SIZE-1:0] cap_rd_q;
    logic [XLEN-1:0]      cap_data_q;
    logic                 ex_valid_q;
    logic [XLEN-1:0]      ex_op1_q, ex_op2_q;
    logic [ADDR_SIZE-1:0] ex_rd_q;

    logic            accept;
    logic [XLEN-1:0] op1_d, op2_d;
    logic            hit1, hit2;

    assign dec_ready = rst && ((state_q == IDLE) || ((state_q == VALID) && ex_ready));
    assign accept    = dec_valid && dec_ready;

    // Register-file read request is issued in the accept cycle itself.
    assign rf_read_enable1 = accept && dec_use_rs1 && (dec_rs1 != '0);
    assign rf_read_enable2 = accept && dec_use_rs2 && (dec_rs2 != '0);
    assign rf_read_addr1   = rf_read_enable1 ? dec_rs1 : '0;
    assign rf_read_addr2   = rf_read_enable2 ? dec_rs2 : '0;

    // Writeback pass-through; x0 is never written.
    assign rf_write_enable = rst && wb_valid && (wb_rd != '0);
    assign rf_write_addr   = wb_rd;
    assign rf_write_data   = wb_data;

    assign ex_valid = ex_valid_q;
    assign ex_op1   = ex_op1_q;
    assign ex_op2   = ex_op2_q;
    assign ex_rd    = ex_rd_q;

    of_bypass #(.XLEN(XLEN), .ADDR_SIZE(ADDR_SIZE)) u_byp1 (
        .use_i       (use1_q),
        .rs_i        (rs1_q),
        .wb_valid_i  (wb_valid),
        .wb_rd_i     (wb_rd),
        .wb_data_i   (wb_data),
        .cap_valid_i (cap_valid_q),
        .cap_rd_i    (cap_rd_q),
        .cap_data_i  (cap_data_q),
        .rf_data_i   (rf_read_data1),
        .op_o        (op1_d),
        .wb_hit_o    (hit1)
    );

    of_bypass #(.XLEN(XLEN), .ADDR_SIZE(ADDR_SIZE)) u_byp2 (
        .use_i       (use2_q),
        .rs_i        (rs2_q),
        .wb_valid_i  (wb_valid),
        .wb_rd_i     (wb_rd),
        .wb_data_i   (wb_data),
        .cap_valid_i (cap_valid_q),
        .cap_rd_i    (cap_rd_q),
        .cap_data_i  (cap_data_q),
        .rf_data_i   (rf_read_data2),
        .op_o        (op2_d),
        .wb_hit_o    (hit2)
    );

    // Control FSM with latched instruction fields and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            use1_q      <= 1'b0;
            use2_q      <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_rd_q    <= '0;
            cap_data_q  <= '0;
            ex_valid_q  <= 1'b0;
            ex_op1_q    <= '0;
            ex_op2_q    <= '0;
            ex_rd_q     <= '0;
        end else begin
            if (accept) begin
                rs1_q       <= dec_rs1;
                rs2_q       <= dec_rs2;
                rd_q        <= dec_rd;
                use1_q      <= dec_use_rs1;
                use2_q      <= dec_use_rs2;
                // RF read data returned next cycle predates this write.
                cap_valid_q <= wb_valid && (wb_rd != '0);
                cap_rd_q    <= wb_rd;
                cap_data_q  <= wb_data;
            end
            case (state_q)
                IDLE: begin
                    if (accept) state_q <= READ;
                end
                READ: begin
                    ex_op1_q   <= op1_d;
                    ex_op2_q   <= op2_d;
                    ex_rd_q    <= rd_q;
                    ex_valid_q <= 1'b1;
                    state_q    <= VALID;
                end
                VALID: begin
                    if (ex_ready) begin
                        ex_valid_q <= 1'b0;
                        state_q    <= accept ? READ : IDLE;
                    end else begin
                        // Keep stalled operands coherent with newer writebacks.
                        if (hit1) ex_op1_q <= wb_data;
                        if (hit2) ex_op2_q <= wb_data;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
